alu_issue_arbiter: RTL and testbench
====================================

// Module: alu_issue_arbiter
// PURPOSE
//  Shares the single 32-bit registered ALU between two requesters (req0, req1).
//  Arbitrates round-robin, holds the operands on the ALU inputs for the required
//  number of cycles and returns a tagged result pulse to the winner.
//  Divide-by-zero and undefined opcodes are trapped and never issued to the ALU.
//  Sits between the decode/issue logic and the ALU; it is the only driver of the
//  ALU A, B and ALUControl inputs.
// PARAMETERS
//  WIDTH       32  operand/result width; must match the ALU
//  MULDIV_LAT  4   EXEC cycles held for op 101 (mul) and op 110 (div); legal range 1..15
// PORTS
//  clk         in   1      single clock; all state changes on its posedge
//  rst         in   1      synchronous, active-high reset
//  req0_valid  in   1      requester 0 has an op; payload is stable while valid && !ready
//  req0_op     in   3      ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mul, 110 div
//  req0_a      in   WIDTH  operand A
//  req0_b      in   WIDTH  operand B
//  req0_ready  out  1      accept strobe; transfer occurs on valid && ready
//  req1_*      (same five signals as req0, for requester 1)
//  alu_a       out  WIDTH  to ALU A (registered)
//  alu_b       out  WIDTH  to ALU B (registered)
//  alu_ctrl    out  3      to ALU ALUControl (registered)
//  alu_result  in   WIDTH  from ALU ALUOut (ALU registers it on posedge clk)
//  rsp_valid   out  1      one-cycle result pulse; no backpressure
//  rsp_id      out  1      requester that owns the response (0/1)
//  rsp_data    out  WIDTH  result; 0 when rsp_valid=0
//  rsp_err     out  1      1 = trapped op (div by zero or op 111)
//  busy        out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1 (req0 wins first tie), cnt=0, alu_a=alu_b=0,
//   alu_ctrl=000, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0, both readys 0.
//  FSM: IDLE -> EXEC -> RESP -> IDLE; IDLE -> TRAP -> IDLE for trapped ops.
//  IDLE: readys are combinational from the valids (ready may depend on valid, never
//   the reverse). Only one requester has ready=1. If exactly one valid, that one
//   wins; if both valid, the winner is !last_grant. No valid: both readys 0.
//  Accept edge: latch winner id; update last_grant := winner.
//   op 110 with B==0, or op 111 -> TRAP; ALU registers unchanged.
//   Otherwise load alu_a/alu_b/alu_ctrl from the winner, cnt := 1 -> EXEC.
//  EXEC: operands held constant. op 101/110 stay MULDIV_LAT cycles (cnt counts up
//   to MULDIV_LAT); all other ops stay 1 cycle. Then -> RESP.
//  RESP: rsp_valid=1, rsp_data=alu_result, rsp_err=0, rsp_id=latched id; -> IDLE.
//  TRAP: rsp_valid=1, rsp_err=1; rsp_data=all-ones for div/0, 0 for op 111; -> IDLE.
//  Latency, accept edge to rsp_valid high: 2 cycles for simple ops, MULDIV_LAT+1
//   for mul/div, 1 for trapped ops. No new accept before the FSM returns to IDLE,
//   so the sustained rate for simple ops is one op every 3 cycles.
//  Results are passed through unmodified: mul is truncated to WIDTH, slt is
//   unsigned, div is unsigned quotient.
//  Reset mid-operation: the op in flight is discarded with no rsp_valid, and
//   last_grant returns to 1.
//  The ALU carry output is not used.
// TESTING
//  1 req0 op000 A=5 B=7 alone -> req0_ready=1 at accept; rsp_valid 2 cycles later, data=12, id=0, err=0
//  2 after reset, req0 op001 10,3 and req1 op011 0xF0,0x0F both valid -> req0 first (data 7),
//    then req1 (data 0xFF); next tie goes to req0 again, strictly alternating
//  3 req1 op101 6*7, MULDIV_LAT=4 -> busy=1 and both readys 0 for 4 EXEC cycles; rsp at
//    accept+5, data=42, id=1
//  4 req0 op110 B=0 -> rsp at accept+1, err=1, data=0xFFFFFFFF, alu_* unchanged; op111 -> err=1, data=0
//  5 rst=1 in the 2nd EXEC cycle of a div -> no rsp_valid; next req1/req0 tie grants req0; all outputs at reset values
//  6 req0 held valid with op000, 3 ops back to back -> accepted every 3 cycles, responses in order, no dropped pulses

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter in front of a single registered ALU: it grants one of two
// requesters, holds the operands for the op's latency, and returns a tagged result pulse.
module alu_issue_arbiter #(
    parameter int WIDTH      = 32,
    parameter int MULDIV_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2,
        ST_TRAP = 2'd3
    } state_t;

    localparam logic [3:0] LAT_C  = 4'(MULDIV_LAT);
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_UND = 3'b111;

    state_t           state_q;
    logic             last_grant_q;
    logic             id_q;
    logic             muldiv_q;
    logic             trap_ones_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_ctrl_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;

    logic             idle;
    logic             grant1;
    logic             accept;
    logic [2:0]       win_op;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             win_div0;
    logic             win_undef;

    assign idle = (state_q == ST_IDLE);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant1 = ~last_grant_q;
        end else begin
            grant1 = req1_valid;
        end
    end

    assign req0_ready = idle && req0_valid && !grant1;
    assign req1_ready = idle && req1_valid && grant1;
    assign accept     = req0_ready || req1_ready;

    assign win_op    = grant1 ? req1_op : req0_op;
    assign win_a     = grant1 ? req1_a  : req0_a;
    assign win_b     = grant1 ? req1_b  : req0_b;
    assign win_div0  = (win_op == OP_DIV) && (win_b == '0);
    assign win_undef = (win_op == OP_UND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            muldiv_q     <= 1'b0;
            trap_ones_q  <= 1'b0;
            cnt_q        <= 4'd0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= 3'b000;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        id_q         <= grant1;
                        last_grant_q <= grant1;
                        if (win_div0 || win_undef) begin
                            // Trapped ops never reach the ALU; its inputs keep their old values.
                            trap_ones_q <= win_div0;
                            state_q     <= ST_TRAP;
                        end else begin
                            alu_a_q    <= win_a;
                            alu_b_q    <= win_b;
                            alu_ctrl_q <= win_op;
                            muldiv_q   <= (win_op == OP_MUL) || (win_op == OP_DIV);
                            cnt_q      <= 4'd1;
                            state_q    <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (!muldiv_q || (cnt_q == LAT_C)) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ST_RESP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= alu_result;
                    rsp_id_q    <= id_q;
                    state_q     <= ST_IDLE;
                end
                ST_TRAP: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_data_q  <= trap_ones_q ? '1 : '0;
                    rsp_id_q    <= id_q;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = !idle;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with a small registered ALU stand-in.
module tb_alu_issue_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [2:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_arbiter #(.WIDTH(32), .MULDIV_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external ALU: result registered on posedge.
    always_ff @(posedge clk) begin
        case (alu_ctrl)
            3'b000:  alu_result <= alu_a + alu_b;
            3'b001:  alu_result <= alu_a - alu_b;
            3'b010:  alu_result <= alu_a & alu_b;
            3'b011:  alu_result <= alu_a | alu_b;
            3'b100:  alu_result <= (alu_a < alu_b) ? 32'd1 : 32'd0;
            3'b101:  alu_result <= alu_a * alu_b;
            3'b110:  alu_result <= (alu_b == 32'd0) ? 32'd0 : alu_a / alu_b;
            default: alu_result <= 32'd0;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_cmp++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 3'd0) begin
            n_bad++; $display("FAIL reset_alu got a=%0h b=%0h c=%0h want 0 0 0", alu_a, alu_b, alu_ctrl); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL reset_rsp got v=%0b id=%0b d=%0h e=%0b want 0 0 0 0", rsp_valid, rsp_id, rsp_data, rsp_err); end
        n_cmp++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready got %0b%0b want 00", req0_ready, req1_ready); end
    endtask

    task automatic test_single;
        req0_op = 3'b000; req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_bad++; $display("FAIL single_ready got %0b%0b want 10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_ctrl !== 3'b000) begin
            n_bad++; $display("FAIL single_issue got busy=%0b a=%0h b=%0h c=%0h want 1 5 7 0", busy, alu_a, alu_b, alu_ctrl); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early got %0b want 0", rsp_valid); end
        tick();
        $display("txn single id=%0b data=%0d err=%0b", rsp_id, rsp_data, rsp_err);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL single_rsp got v=%0b d=%0h id=%0b e=%0b want 1 c 0 0", rsp_valid, rsp_data, rsp_id, rsp_err); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
            n_bad++; $display("FAIL single_pulse got v=%0b d=%0h want 0 0", rsp_valid, rsp_data); end
    endtask

    task automatic test_round_robin;
        do_reset();
        req0_op = 3'b001; req0_a = 32'd10;   req0_b = 32'd3;
        req1_op = 3'b011; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            logic        exp_id;
            logic [31:0] exp_data;
            exp_id   = (k % 2 == 1);
            exp_data = exp_id ? 32'h0000_00FF : 32'd7;
            n_cmp++; if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
                n_bad++; $display("FAIL rr_ready[%0d] got %0b%0b want %0b%0b", k, req0_ready, req1_ready, !exp_id, exp_id); end
            tick();
            n_cmp++; if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_bad++; $display("FAIL rr_busy[%0d] got busy=%0b rdy=%0b%0b want 1 00", k, busy, req0_ready, req1_ready); end
            tick();
            tick();
            $display("txn rr[%0d] id=%0b data=%0h", k, rsp_id, rsp_data);
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_data) begin
                n_bad++; $display("FAIL rr_rsp[%0d] got v=%0b id=%0b d=%0h want 1 %0b %0h", k, rsp_valid, rsp_id, rsp_data, exp_id, exp_data); end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_muldiv;
        do_reset();
        req1_op = 3'b101; req1_a = 32'd6; req1_b = 32'd7; req1_valid = 1'b1;
        #1;
        n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL mul_ready got %0b want 1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd1; req0_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b0 || alu_ctrl !== 3'b101) begin
                n_bad++; $display("FAIL mul_exec[%0d] got busy=%0b rdy=%0b%0b v=%0b c=%0h want 1 00 0 5", c, busy, req0_ready, req1_ready, rsp_valid, alu_ctrl); end
            tick();
        end
        req0_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL mul_resp_state got busy=%0b v=%0b want 1 0", busy, rsp_valid); end
        tick();
        $display("txn mul id=%0b data=%0d", rsp_id, rsp_data);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd42 || rsp_id !== 1'b1 || rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL mul_rsp got v=%0b d=%0h id=%0b e=%0b want 1 2a 1 0", rsp_valid, rsp_data, rsp_id, rsp_err); end
    endtask

    task automatic test_trap;
        req0_op = 3'b110; req0_a = 32'd100; req0_b = 32'd0; req0_valid = 1'b1;
        #1;
        tick();
        req0_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1 || alu_a !== 32'd6 || alu_b !== 32'd7 || alu_ctrl !== 3'b101) begin
            n_bad++; $display("FAIL div0_alu got busy=%0b a=%0h b=%0h c=%0h want 1 6 7 5", busy, alu_a, alu_b, alu_ctrl); end
        tick();
        $display("txn div0 id=%0b data=%0h err=%0b", rsp_id, rsp_data, rsp_err);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_id !== 1'b0) begin
            n_bad++; $display("FAIL div0_rsp got v=%0b e=%0b d=%0h id=%0b want 1 1 ffffffff 0", rsp_valid, rsp_err, rsp_data, rsp_id); end
        req0_op = 3'b111; req0_a = 32'd3; req0_b = 32'd3; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        $display("txn op111 id=%0b data=%0h err=%0b", rsp_id, rsp_data, rsp_err);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'd0 || alu_ctrl !== 3'b101) begin
            n_bad++; $display("FAIL undef_rsp got v=%0b e=%0b d=%0h c=%0h want 1 1 0 5", rsp_valid, rsp_err, rsp_data, alu_ctrl); end
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        req0_op = 3'b110; req0_a = 32'd20; req0_b = 32'd4; req0_valid = 1'b1;
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b1 || alu_ctrl !== 3'b110) begin
            n_bad++; $display("FAIL mid_exec got busy=%0b c=%0h want 1 6", busy, alu_ctrl); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 3'd0 || rsp_valid !== 1'b0 || rsp_data !== 32'd0) begin
            n_bad++; $display("FAIL mid_reset got busy=%0b a=%0h b=%0h c=%0h v=%0b d=%0h want all 0", busy, alu_a, alu_b, alu_ctrl, rsp_valid, rsp_data); end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_norsp[%0d] got %0b want 0", c, rsp_valid); end
        end
        req0_op = 3'b000; req0_a = 32'd1; req0_b = 32'd2;
        req1_op = 3'b000; req1_a = 32'd3; req1_b = 32'd4;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_bad++; $display("FAIL mid_tie got %0b%0b want 10", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [3];
        logic [31:0] tb_ [3];
        logic [31:0] te [3];
        ta[0] = 32'd1;         tb_[0] = 32'd2;   te[0] = 32'd3;
        ta[1] = 32'd100;       tb_[1] = 32'd200; te[1] = 32'd300;
        ta[2] = 32'hFFFF_FFFF; tb_[2] = 32'd1;   te[2] = 32'd0;
        do_reset();
        req0_op = 3'b000; req0_a = ta[0]; req0_b = tb_[0]; req0_valid = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %0b want 1", k, req0_ready); end
            tick();
            if (k < 2) begin
                req0_a = ta[k+1]; req0_b = tb_[k+1];
            end else begin
                req0_valid = 1'b0;
            end
            #1;
            n_cmp++; if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold[%0d] got %0b want 0", k, req0_ready); end
            tick();
            tick();
            $display("txn b2b[%0d] id=%0b data=%0h", k, rsp_id, rsp_data);
            n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== te[k]) begin
                n_bad++; $display("FAIL b2b_rsp[%0d] got v=%0b id=%0b d=%0h want 1 0 %0h", k, rsp_valid, rsp_id, rsp_data, te[k]); end
        end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b_end got v=%0b busy=%0b want 0 0", rsp_valid, busy); end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = 32'd0; req1_b = 32'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_muldiv();
        test_trap();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
